// File: rtl/sha3_msg_sequencer_if.sv
// ---------------------------------------------------------------------------
// sha3_msg_sequencer_if
//   Bundles the three handshakes of the SHA3 message sequencer:
//     message stream : msg_data/msg_valid/msg_last/msg_bytes -> msg_ready
//     core side      : core_in/core_in_valid/core_more -> core_hash_next/
//                      core_out_valid/core_out
//     digest output  : digest/digest_valid <- digest_ready, plus busy/err
//   Optional SHA3_SEQ_PERF_EN adds blk_count/msg_count.
//   Modports:
//     slave  - the sequencer itself
//     master - the environment (message source, core, digest consumer)
// ---------------------------------------------------------------------------
interface sha3_msg_sequencer_if;
  logic [63:0]   msg_data;
  logic          msg_valid;
  logic          msg_last;
  logic [3:0]    msg_bytes;
  logic          msg_ready;

  logic [1087:0] core_in;
  logic          core_in_valid;
  logic          core_more;
  logic          core_hash_next;
  logic          core_out_valid;
  logic [255:0]  core_out;

  logic [255:0]  digest;
  logic          digest_valid;
  logic          digest_ready;
  logic          busy;
  logic          err;
`ifdef SHA3_SEQ_PERF_EN
  logic [15:0]   blk_count;
  logic [31:0]   msg_count;
`endif

  modport slave (
    input  msg_data, msg_valid, msg_last, msg_bytes,
    output msg_ready,
    output core_in, core_in_valid, core_more,
    input  core_hash_next, core_out_valid, core_out,
    output digest, digest_valid,
    input  digest_ready,
    output busy, err
`ifdef SHA3_SEQ_PERF_EN
    , output blk_count, msg_count
`endif
  );

  modport master (
    output msg_data, msg_valid, msg_last, msg_bytes,
    input  msg_ready,
    input  core_in, core_in_valid, core_more,
    output core_hash_next, core_out_valid, core_out,
    input  digest, digest_valid,
    output digest_ready,
    input  busy, err
`ifdef SHA3_SEQ_PERF_EN
    , input blk_count, msg_count
`endif
  );
endinterface

// File: rtl/sha3_msg_sequencer.sv
// ---------------------------------------------------------------------------
// sha3_msg_sequencer
//   Packs a 64-bit big-endian byte stream into 1088-bit SHA3-256 rate blocks,
//   applies SHA3 padding (DS_SUFFIX at the first free byte, 0x80 OR-ed into
//   byte 135), issues each block to the permutation core with the proper
//   core_more flag, waits for the core's completion and holds the 256-bit
//   digest behind a valid/ready handshake.
//
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset
//     bus  - sha3_msg_sequencer_if.slave (message in, core, digest out,
//            busy, sticky watchdog/protocol err)
//
//   Parameters:
//     DS_SUFFIX   - domain-separation byte (8'h06 SHA3, 8'h1F SHAKE)
//     WDOG_CYCLES - cycles allowed from block issue to core completion
//
//   Optional feature macro: SHA3_SEQ_PERF_EN
//     adds blk_count (blocks issued in current message, saturating) and
//     msg_count (digests delivered, wrapping).
//
//   Block layout: byte n lives at core_in[1087-8n -: 8]; the buffer is held
//   as a packed [0:135] byte array so index n maps straight onto byte n.
// ---------------------------------------------------------------------------
module sha3_msg_sequencer #(
  parameter logic [7:0]  DS_SUFFIX   = 8'h06,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  sha3_msg_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, FILL, ISSUE, WAIT, PADBLK, DONE
  } state_t;

  localparam int WDW = $clog2(WDOG_CYCLES + 1);

  // Block used when the message ended exactly on a block boundary.
  localparam logic [0:135][7:0] PAD_ONLY = {DS_SUFFIX, {134{8'h00}}, 8'h80};

  state_t              state;
  logic [4:0]          word_idx;
  logic [0:135][7:0]   blk;
  logic [0:135][7:0]   blk_next;
  logic                core_in_valid_q;
  logic                core_more_q;
  logic                pad_pending;
  logic                msg_ready_q;
  logic [WDW-1:0]      wdog;
  logic [255:0]        digest_q;
  logic                digest_valid_q;
  logic                err_q;
`ifdef SHA3_SEQ_PERF_EN
  logic [15:0]         blk_count_q;
  logic [31:0]         msg_count_q;
`endif

  logic [0:7][7:0]     data_bytes;
  logic                full_word;
  logic                last_idx;
  logic                proto_err;
  logic                wdog_expired;

  assign data_bytes = bus.msg_data;
  // Out-of-range byte counts (9..15) are treated as a full word.
  assign full_word  = (bus.msg_bytes >= 4'd8);
  assign last_idx   = (word_idx == 5'd16);

  // Completion polarity must agree with the core_more flag we issued.
  assign proto_err    = (bus.core_out_valid && core_more_q) ||
                        (!bus.core_out_valid && bus.core_hash_next && !core_more_q);
  assign wdog_expired = !bus.core_out_valid && !bus.core_hash_next && (wdog == '0);

  // Buffer contents after accepting the word currently on msg_data,
  // including padding when that word ends the message with room left.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path
    // leaves it unassigned; that is what keeps a latch from being inferred.
    blk_next = blk;
    for (int b = 0; b < 8; b++) begin
      if (!bus.msg_last || full_word || (4'(b) < bus.msg_bytes))
        blk_next[{word_idx, 3'(b)}] = data_bytes[3'(b)];
      else
        blk_next[{word_idx, 3'(b)}] = 8'h00;
    end
    if (bus.msg_last) begin
      if (!full_word) begin
        blk_next[{word_idx, bus.msg_bytes[2:0]}] = DS_SUFFIX;
        blk_next[135] = blk_next[135] | 8'h80;
      end else if (!last_idx) begin
        blk_next[{word_idx + 5'd1, 3'b000}] = DS_SUFFIX;
        blk_next[135] = blk_next[135] | 8'h80;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register sees the pre-edge values of the others.
    if (rst) begin
      state           <= IDLE;
      word_idx        <= '0;
      // NOTE: the block buffer is a register bank, not a RAM, and padding
      // only writes selected bytes into it, so it must start from zero.
      blk             <= '0;
      core_in_valid_q <= 1'b0;
      core_more_q     <= 1'b0;
      pad_pending     <= 1'b0;
      msg_ready_q     <= 1'b1;
      wdog            <= '0;
      digest_q        <= '0;
      digest_valid_q  <= 1'b0;
      err_q           <= 1'b0;
`ifdef SHA3_SEQ_PERF_EN
      blk_count_q     <= '0;
      msg_count_q     <= '0;
`endif
    end else begin
      core_in_valid_q <= 1'b0;
      unique case (state)
        IDLE, FILL: begin
          if (bus.msg_valid) begin
            blk <= blk_next;
            if (bus.msg_last) begin
              word_idx        <= '0;
              msg_ready_q     <= 1'b0;
              core_in_valid_q <= 1'b1;
              state           <= ISSUE;
              // A full final word in the last slot leaves no pad room:
              // the padding goes into an extra block.
              if (full_word && last_idx) begin
                core_more_q <= 1'b1;
                pad_pending <= 1'b1;
              end else begin
                core_more_q <= 1'b0;
              end
            end else if (last_idx) begin
              word_idx        <= '0;
              core_more_q     <= 1'b1;
              msg_ready_q     <= 1'b0;
              core_in_valid_q <= 1'b1;
              state           <= ISSUE;
            end else begin
              word_idx <= word_idx + 5'd1;
              state    <= FILL;
            end
          end
        end

        ISSUE: begin
          wdog  <= WDW'(WDOG_CYCLES);
          state <= WAIT;
`ifdef SHA3_SEQ_PERF_EN
          if (blk_count_q != 16'hFFFF)
            blk_count_q <= blk_count_q + 16'd1;
`endif
        end

        WAIT: begin
          if (proto_err || wdog_expired) begin
            err_q       <= 1'b1;
            state       <= IDLE;
            msg_ready_q <= 1'b1;
            blk         <= '0;
            word_idx    <= '0;
            core_more_q <= 1'b0;
            pad_pending <= 1'b0;
`ifdef SHA3_SEQ_PERF_EN
            blk_count_q <= '0;
`endif
          end else if (bus.core_out_valid) begin
            digest_q       <= bus.core_out;
            digest_valid_q <= 1'b1;
            state          <= DONE;
          end else if (bus.core_hash_next) begin
            if (pad_pending) begin
              state <= PADBLK;
            end else begin
              blk         <= '0;
              msg_ready_q <= 1'b1;
              state       <= FILL;
            end
          end else begin
            wdog <= wdog - 1'b1;
          end
        end

        PADBLK: begin
          blk             <= PAD_ONLY;
          core_more_q     <= 1'b0;
          pad_pending     <= 1'b0;
          core_in_valid_q <= 1'b1;
          state           <= ISSUE;
        end

        DONE: begin
          if (bus.digest_ready) begin
            digest_valid_q <= 1'b0;
            msg_ready_q    <= 1'b1;
            blk            <= '0;
            core_more_q    <= 1'b0;
            state          <= IDLE;
`ifdef SHA3_SEQ_PERF_EN
            blk_count_q    <= '0;
            msg_count_q    <= msg_count_q + 32'd1;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.msg_ready     = msg_ready_q;
  assign bus.core_in       = blk;
  assign bus.core_in_valid = core_in_valid_q;
  assign bus.core_more     = core_more_q;
  assign bus.digest        = digest_q;
  assign bus.digest_valid  = digest_valid_q;
  assign bus.busy          = (state != IDLE);
  assign bus.err           = err_q;
`ifdef SHA3_SEQ_PERF_EN
  assign bus.blk_count     = blk_count_q;
  assign bus.msg_count     = msg_count_q;
`endif

endmodule
